mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter and sequencer sharing the single-port main memory (4096 x 16) between three requesters: instruction fetch, execute-phase data access, and the I/O/DMA port. It sits between the control unit/datapath and the memory array. It serialises accesses, drives the memory strobes for a fixed read latency, and returns a one-cycle acknowledge with read data. A lock input from the data port keeps ISZ-style read-modify-write sequences atomic.

## Interface
- AW, 12, address width
- DW, 16, data width
- MEM_LAT, 1, memory read latency in cycles (legal 1..7)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch request (read only)
- f_addr  in  AW  fetch address
- d_req  in  1  data request
- d_addr  in  AW  data address
- d_we  in  1  data write enable
- d_wdata  in  DW  data write value
- d_lock  in  1  hold grant for the data port's next access
- io_req  in  1  I/O request
- io_addr  in  AW  I/O address
- io_we  in  1  I/O write enable
- io_wdata  in  DW  I/O write value
- gnt  out  3  one-hot grant {io, d, f}
- ack  out  3  one-hot, one-cycle completion pulse {io, d, f}
- rdata  out  DW  read data, valid while ack is high
- busy  out  1  access in progress (state != IDLE)
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req is high, select a winner and latch its addr/we/wdata (fetch: we=0). Load cnt=MEM_LAT-1, set gnt, go to ACCESS. With no request, stay in IDLE.
- Selection: round-robin over order f(0), d(1), io(2), starting at pointer ptr. If lock_held=1, only d_req is eligible. Other requests wait.
- ACCESS: mem_en=1 and mem_we=latched we in the first ACCESS cycle only. mem_addr/mem_wdata hold the latched values for the whole state. cnt decrements each cycle. When cnt==0, capture mem_rdata into rdata (writes capture nothing; rdata keeps its previous value) and go to DONE.
- DONE: ack[winner]=1 for exactly this cycle. Then go to IDLE, clear gnt, and set ptr = winner+1 (mod 3).
- Lock: in DONE with winner=d, set lock_held=d_lock. A DONE for any other winner leaves lock_held unchanged (it can only be 0 then).
- A requester holds req until ack. If req drops mid-access, the access still completes and ack still pulses. If req is still high in the cycle after ack, that is a new request.
- Reset values: state=IDLE, ptr=0, lock_held=0, gnt=0, ack=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset during ACCESS/DONE: the access is abandoned with no ack. Memory sees no further strobes.

## Timing
- Request sampled in IDLE at edge E. ACCESS occupies cycles E..E+MEM_LAT-1, DONE is cycle E+MEM_LAT, and IDLE is re-entered at E+MEM_LAT+1.
- req-to-ack latency: MEM_LAT+1 cycles after the sampling edge. Throughput: one access per MEM_LAT+2 cycles.
- gnt is high from ACCESS entry through DONE inclusive.
- Simultaneous requests are resolved only in IDLE. Requests arriving during ACCESS/DONE wait.
- All outputs are registered or decoded from registered state only. There is no combinational path from req to mem_*.

## Structure
- Shared package (cpu_pkg): AW/DW constants, state encoding (IDLE=0, ACCESS=1, DONE=2), port index constants (PORT_F=0, PORT_D=1, PORT_IO=2).
- One sub-module: rr_pick3 (combinational 3-way round-robin picker: req[2:0], ptr, mask → one-hot winner). Everything else goes in mem_arbiter.

## Test plan
- Reset, then f_req=1 with f_addr=0x010 and memory word 0x010=0xBEEF (MEM_LAT=1): mem_en for one cycle at 0x010; ack[0]=1 with rdata=0xBEEF two cycles after the sampling edge.
- f_req, d_req and io_req all held high from reset: grant order f, d, io, f, ...; each ack is exactly one cycle, and a new grant follows every 3 cycles.
- d_req write 0x1234 to 0x2A0 with d_we=1, then f_req read of 0x2A0: mem_we=1 once; the read returns 0x1234; rdata is unchanged at the write ack.
- ISZ sequence: d_lock=1 on a read of 0x055 with f_req and io_req also pending; the next grant goes to d (write 0x055) even though ptr points to io; after d_lock=0, io is granted next.
- MEM_LAT=3: mem_en high for 1 cycle; ack 4 cycles after the sampling edge; busy high for 4 cycles.
- Reset asserted in the second ACCESS cycle: no ack; all outputs 0 the next cycle; a fresh request then starts with the fetch port preferred.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter_pkg                                               |
// | Purpose  : Shared constants, FSM state encoding and port indices for the |
// |            main-memory arbiter and its round-robin picker.               |
// | Contents : c_AW / c_DW     default address / data widths                 |
// |            c_PORT_*        bit positions of f / d / io in gnt and ack    |
// |            state_t         IDLE / ACCESS / DONE encoding                 |
// |            next_ptr()      round-robin pointer after a one-hot winner    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int c_AW = 12;
  localparam int c_DW = 16;

  localparam int c_PORT_F  = 0;
  localparam int c_PORT_D  = 1;
  localparam int c_PORT_IO = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Pointer moves to the port just after the one that was served.
  function automatic logic [1:0] next_ptr(input logic [2:0] winner);
    logic [1:0] w_ptr;
    if (winner[c_PORT_F])      w_ptr = 2'd1;
    else if (winner[c_PORT_D]) w_ptr = 2'd2;
    else                       w_ptr = 2'd0;
    return w_ptr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter_if                                                |
// | Purpose  : Bundles the three requester ports, the grant/ack/read-data    |
// |            return path and the memory strobes of the arbiter.            |
// | Modports : slave  - arbiter view (requests in, grants and strobes out)   |
// |            master - requester/memory view (requests out, grants in,      |
// |                     mem_rdata out)                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = c_AW,
  parameter int DW = c_DW
);

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [DW-1:0] d_wdata;
  logic          d_lock;
  logic          io_req;
  logic [AW-1:0] io_addr;
  logic          io_we;
  logic [DW-1:0] io_wdata;
  logic [2:0]    gnt;
  logic [2:0]    ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr,
    input  d_req, d_addr, d_we, d_wdata, d_lock,
    input  io_req, io_addr, io_we, io_wdata,
    output gnt, ack, rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req, f_addr,
    output d_req, d_addr, d_we, d_wdata, d_lock,
    output io_req, io_addr, io_we, io_wdata,
    input  gnt, ack, rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_pick3                                                      |
// | Purpose  : Combinational 3-way round-robin picker. The first eligible    |
// |            request found when scanning upward from ptr (wrapping 2->0)   |
// |            wins.                                                         |
// | Ports    : req[2:0]    raw requests {io, d, f}                           |
// |            ptr[1:0]    index scanned first (0..2)                        |
// |            mask[2:0]   eligibility mask, 1 = may win                     |
// |            winner[2:0] one-hot winner, all zero if nothing eligible      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_pick3
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [2:0] mask,
  output logic [2:0] winner
);

  logic [2:0] w_elig;

  assign w_elig = req & mask;

  always_comb begin
    winner = 3'b000;
    case (ptr)
      2'd1: begin
        if (w_elig[c_PORT_D])       winner = 3'b010;
        else if (w_elig[c_PORT_IO]) winner = 3'b100;
        else if (w_elig[c_PORT_F])  winner = 3'b001;
      end
      2'd2: begin
        if (w_elig[c_PORT_IO])      winner = 3'b100;
        else if (w_elig[c_PORT_F])  winner = 3'b001;
        else if (w_elig[c_PORT_D])  winner = 3'b010;
      end
      default: begin
        if (w_elig[c_PORT_F])       winner = 3'b001;
        else if (w_elig[c_PORT_D])  winner = 3'b010;
        else if (w_elig[c_PORT_IO]) winner = 3'b100;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                   |
// | Purpose  : Round-robin arbiter/sequencer sharing one single-port memory  |
// |            between fetch, data and I/O requesters. One access at a time: |
// |            IDLE picks a winner, ACCESS strobes the memory and waits      |
// |            MEM_LAT cycles, DONE pulses ack for one cycle.                |
// | Ports    : clk, reset  clock and synchronous active-high reset          |
// |            bus         mem_arbiter_if.slave: requests, gnt/ack/rdata,    |
// |                        busy and the memory strobe/address/data signals   |
// | Params   : AW, DW      address / data widths                            |
// |            MEM_LAT     memory read latency in cycles (1..7)              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = c_AW,
  parameter int DW      = c_DW,
  parameter int MEM_LAT = 1
)
(
  input  logic            clk,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);

  localparam logic [2:0] c_CNT_INIT = 3'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_ptr;
  logic          r_lock_held;
  logic [2:0]    r_gnt;
  logic [2:0]    r_ack;
  logic [2:0]    r_cnt;
  logic          r_we;
  logic [DW-1:0] r_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic [2:0]    w_req;
  logic [2:0]    w_mask;
  logic [2:0]    w_win;
  logic          w_any;

  assign w_req  = {bus.io_req, bus.d_req, bus.f_req};
  // While a locked read-modify-write is in progress only the data port may win.
  assign w_mask = r_lock_held ? 3'b010 : 3'b111;
  assign w_any  = |w_win;

  rr_pick3 u_pick (
    .req    (w_req),
    .ptr    (r_ptr),
    .mask   (w_mask),
    .winner (w_win)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ACCESS;
      ACCESS:  if (r_cnt == 3'd0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: all outputs are registered so nothing combinational reaches mem_*.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= 2'd0;
      r_lock_held <= 1'b0;
      r_gnt       <= 3'b000;
      r_ack       <= 3'b000;
      r_cnt       <= 3'd0;
      r_we        <= 1'b0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      // Strobes and ack are single-cycle pulses by default.
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_ack    <= 3'b000;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt    <= w_win;
            r_cnt    <= c_CNT_INIT;
            r_mem_en <= 1'b1;
            if (w_win[c_PORT_D]) begin
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
              r_we        <= bus.d_we;
              r_mem_we    <= bus.d_we;
            end else if (w_win[c_PORT_IO]) begin
              r_mem_addr  <= bus.io_addr;
              r_mem_wdata <= bus.io_wdata;
              r_we        <= bus.io_we;
              r_mem_we    <= bus.io_we;
            end else begin
              r_mem_addr  <= bus.f_addr;
              r_mem_wdata <= '0;
              r_we        <= 1'b0;
              r_mem_we    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            // Writes leave the previous read data visible.
            if (!r_we) r_rdata <= bus.mem_rdata;
            r_ack <= r_gnt;
          end
        end
        DONE: begin
          r_gnt <= 3'b000;
          r_ptr <= next_ptr(r_gnt);
          if (r_gnt[c_PORT_D]) r_lock_held <= bus.d_lock;
        end
        default: begin
          r_gnt <= 3'b000;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.ack       = r_ack;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                |
// | Purpose  : Directed self-checking bench for mem_arbiter. Two instances:  |
// |            dut1 with MEM_LAT=1 and dut3 with MEM_LAT=3, each with its    |
// |            own behavioural memory honouring that latency.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  mem_arbiter_if #(.AW(12), .DW(16)) b1 ();
  mem_arbiter_if #(.AW(12), .DW(16)) b3 ();

  mem_arbiter #(.AW(12), .DW(16), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  mem_arbiter #(.AW(12), .DW(16), .MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models. Writes and backdoor preloads land mid-cycle on the falling edge.
  logic [15:0] mem1 [0:4095];
  logic [15:0] mem3 [0:4095];
  logic        bd_req;
  logic        bd_sel;
  logic [11:0] bd_addr;
  logic [15:0] bd_data;

  always @(negedge clk) begin
    if (bd_req && !bd_sel) mem1[bd_addr] <= bd_data;
    if (bd_req &&  bd_sel) mem3[bd_addr] <= bd_data;
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
  end

  // Latency 1: data valid during the strobe cycle. Latency 3: two register stages after it.
  logic [15:0] m3_s0, m3_p1, m3_p2;
  assign b1.mem_rdata = b1.mem_en ? mem1[b1.mem_addr] : 16'hDEAD;
  assign m3_s0        = b3.mem_en ? mem3[b3.mem_addr] : 16'hDEAD;
  always @(posedge clk) begin
    m3_p1 <= m3_s0;
    m3_p2 <= m3_p1;
  end
  assign b3.mem_rdata = m3_p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [11:0] addr, input logic [15:0] data);
    bd_sel  = sel;
    bd_addr = addr;
    bd_data = data;
    bd_req  = 1'b1;
    @(negedge clk);
    #1;
    bd_req  = 1'b0;
  endtask

  task automatic clear_inputs();
    b1.f_req = 0; b1.f_addr = '0; b1.d_req = 0; b1.d_addr = '0; b1.d_we = 0;
    b1.d_wdata = '0; b1.d_lock = 0; b1.io_req = 0; b1.io_addr = '0; b1.io_we = 0; b1.io_wdata = '0;
    b3.f_req = 0; b3.f_addr = '0; b3.d_req = 0; b3.d_addr = '0; b3.d_we = 0;
    b3.d_wdata = '0; b3.d_lock = 0; b3.io_req = 0; b3.io_addr = '0; b3.io_we = 0; b3.io_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_total++; if ({b1.gnt, b1.ack, b1.busy, b1.mem_en, b1.mem_we} !== 9'd0)
      $display("FAIL reset_ctl1: got %b want 0", {b1.gnt, b1.ack, b1.busy, b1.mem_en, b1.mem_we}); else n_pass++;
    n_total++; if ({b1.rdata, b1.mem_addr, b1.mem_wdata} !== 44'd0)
      $display("FAIL reset_data1: got %h want 0", {b1.rdata, b1.mem_addr, b1.mem_wdata}); else n_pass++;
    n_total++; if ({b3.gnt, b3.ack, b3.busy, b3.mem_en, b3.mem_we} !== 9'd0)
      $display("FAIL reset_ctl3: got %b want 0", {b3.gnt, b3.ack, b3.busy, b3.mem_en, b3.mem_we}); else n_pass++;
    n_total++; if ({b3.rdata, b3.mem_addr, b3.mem_wdata} !== 44'd0)
      $display("FAIL reset_data3: got %h want 0", {b3.rdata, b3.mem_addr, b3.mem_wdata}); else n_pass++;
  endtask

  task automatic test_fetch_read();
    preload(1'b0, 12'h010, 16'hBEEF);
    b1.f_req  = 1'b1;
    b1.f_addr = 12'h010;
    tick();  // ACCESS
    n_total++; if ({b1.mem_en, b1.mem_we, b1.gnt, b1.busy} !== 6'b10_001_1)
      $display("FAIL fetch_access: got %b want 100011", {b1.mem_en, b1.mem_we, b1.gnt, b1.busy}); else n_pass++;
    n_total++; if (b1.mem_addr !== 12'h010)
      $display("FAIL fetch_addr: got %h want 010", b1.mem_addr); else n_pass++;
    tick();  // DONE
    n_total++; if ({b1.ack, b1.mem_en} !== 4'b001_0)
      $display("FAIL fetch_ack: got %b want 0010", {b1.ack, b1.mem_en}); else n_pass++;
    n_total++; if (b1.rdata !== 16'hBEEF)
      $display("FAIL fetch_rdata: got %h want beef", b1.rdata); else n_pass++;
    b1.f_req = 1'b0;
    tick();  // IDLE
    n_total++; if ({b1.ack, b1.gnt, b1.busy} !== 7'd0)
      $display("FAIL fetch_idle: got %b want 0", {b1.ack, b1.gnt, b1.busy}); else n_pass++;
  endtask

  task automatic test_write_then_read();
    // Pointer sits at d after the fetch.
    b1.d_req = 1'b1; b1.d_addr = 12'h2A0; b1.d_we = 1'b1; b1.d_wdata = 16'h1234;
    tick();
    n_total++; if ({b1.gnt, b1.mem_en, b1.mem_we} !== 5'b010_1_1)
      $display("FAIL wr_strobe: got %b want 01011", {b1.gnt, b1.mem_en, b1.mem_we}); else n_pass++;
    n_total++; if ({b1.mem_addr, b1.mem_wdata} !== {12'h2A0, 16'h1234})
      $display("FAIL wr_bus: got %h want 2a01234", {b1.mem_addr, b1.mem_wdata}); else n_pass++;
    tick();
    n_total++; if ({b1.ack, b1.mem_we} !== 4'b010_0)
      $display("FAIL wr_ack: got %b want 0100", {b1.ack, b1.mem_we}); else n_pass++;
    n_total++; if (b1.rdata !== 16'hBEEF)
      $display("FAIL wr_rdata_kept: got %h want beef", b1.rdata); else n_pass++;
    b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.f_req = 1'b1; b1.f_addr = 12'h2A0;
    tick();
    tick();
    n_total++; if ({b1.gnt, b1.mem_we} !== 4'b001_0)
      $display("FAIL rd_gnt: got %b want 0010", {b1.gnt, b1.mem_we}); else n_pass++;
    tick();
    n_total++; if ({b1.ack, b1.rdata} !== {3'b001, 16'h1234})
      $display("FAIL rd_back: got %h want 1_1234", {b1.ack, b1.rdata}); else n_pass++;
    b1.f_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g;
    logic [11:0] exp_a;
    reset = 1'b1;
    b1.f_req = 1; b1.f_addr = 12'h100;
    b1.d_req = 1; b1.d_addr = 12'h200; b1.d_we = 0;
    b1.io_req = 1; b1.io_addr = 12'h300; b1.io_we = 0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0:       begin exp_g = 3'b001; exp_a = 12'h100; end
        1:       begin exp_g = 3'b010; exp_a = 12'h200; end
        default: begin exp_g = 3'b100; exp_a = 12'h300; end
      endcase
      tick();
      n_total++; if ({b1.gnt, b1.mem_addr} !== {exp_g, exp_a})
        $display("FAIL rr_gnt%0d: got %b/%h want %b/%h", i, b1.gnt, b1.mem_addr, exp_g, exp_a); else n_pass++;
      tick();
      n_total++; if (b1.ack !== exp_g)
        $display("FAIL rr_ack%0d: got %b want %b", i, b1.ack, exp_g); else n_pass++;
      tick();
      n_total++; if ({b1.ack, b1.gnt} !== 6'd0)
        $display("FAIL rr_idle%0d: got %b want 0", i, {b1.ack, b1.gnt}); else n_pass++;
    end
    b1.f_req = 0; b1.d_req = 0; b1.io_req = 0;
    tick();
  endtask

  task automatic test_isz();
    preload(1'b0, 12'h055, 16'h0007);
    // Pointer is at f after the round-robin run.
    b1.f_req = 1; b1.f_addr = 12'h011;
    b1.d_req = 1; b1.d_addr = 12'h055; b1.d_we = 0; b1.d_lock = 1;
    b1.io_req = 1; b1.io_addr = 12'h300; b1.io_we = 0;
    tick();
    n_total++; if (b1.gnt !== 3'b001) $display("FAIL isz_first: got %b want 001", b1.gnt); else n_pass++;
    tick();
    tick();
    tick();
    n_total++; if ({b1.gnt, b1.mem_addr, b1.mem_we} !== {3'b010, 12'h055, 1'b0})
      $display("FAIL isz_rd_gnt: got %b/%h/%b want 010/055/0", b1.gnt, b1.mem_addr, b1.mem_we); else n_pass++;
    tick();
    n_total++; if ({b1.ack, b1.rdata} !== {3'b010, 16'h0007})
      $display("FAIL isz_rd_ack: got %h want 2_0007", {b1.ack, b1.rdata}); else n_pass++;
    b1.d_we = 1; b1.d_wdata = 16'h0008;
    tick();
    tick();
    n_total++; if ({b1.gnt, b1.mem_we, b1.mem_wdata} !== {3'b010, 1'b1, 16'h0008})
      $display("FAIL isz_locked_gnt: got %b/%b/%h want 010/1/0008", b1.gnt, b1.mem_we, b1.mem_wdata); else n_pass++;
    b1.d_lock = 0;
    tick();
    n_total++; if ({b1.ack, b1.rdata} !== {3'b010, 16'h0007})
      $display("FAIL isz_wr_ack: got %h want 2_0007", {b1.ack, b1.rdata}); else n_pass++;
    n_total++; if (mem1[12'h055] !== 16'h0008)
      $display("FAIL isz_mem: got %h want 0008", mem1[12'h055]); else n_pass++;
    b1.d_req = 0; b1.d_we = 0;
    tick();
    tick();
    n_total++; if (b1.gnt !== 3'b100) $display("FAIL isz_unlock_io: got %b want 100", b1.gnt); else n_pass++;
    tick();
    b1.io_req = 0;
    tick();
    tick();
    n_total++; if (b1.gnt !== 3'b001) $display("FAIL isz_then_f: got %b want 001", b1.gnt); else n_pass++;
    tick();
    b1.f_req = 0;
    tick();
  endtask

  task automatic test_latency3();
    preload(1'b1, 12'h123, 16'hA5A5);
    b3.f_req = 1; b3.f_addr = 12'h123;
    tick();
    n_total++; if ({b3.mem_en, b3.busy, b3.ack} !== 5'b11_000)
      $display("FAIL lat3_c0: got %b want 11000", {b3.mem_en, b3.busy, b3.ack}); else n_pass++;
    tick();
    n_total++; if ({b3.mem_en, b3.busy, b3.ack} !== 5'b01_000)
      $display("FAIL lat3_c1: got %b want 01000", {b3.mem_en, b3.busy, b3.ack}); else n_pass++;
    tick();
    n_total++; if ({b3.mem_en, b3.busy, b3.ack} !== 5'b01_000)
      $display("FAIL lat3_c2: got %b want 01000", {b3.mem_en, b3.busy, b3.ack}); else n_pass++;
    tick();
    n_total++; if ({b3.busy, b3.ack, b3.rdata} !== {1'b1, 3'b001, 16'hA5A5})
      $display("FAIL lat3_ack: got %b/%b/%h want 1/001/a5a5", b3.busy, b3.ack, b3.rdata); else n_pass++;
    b3.f_req = 0;
    tick();
    n_total++; if ({b3.busy, b3.ack} !== 4'd0)
      $display("FAIL lat3_idle: got %b want 0", {b3.busy, b3.ack}); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    // Pointer is at d; a data read is abandoned by reset.
    b3.d_req = 1; b3.d_addr = 12'h050; b3.d_we = 0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_total++; if ({b3.gnt, b3.ack, b3.busy, b3.mem_en, b3.mem_we} !== 9'd0)
      $display("FAIL rst_mid_ctl: got %b want 0", {b3.gnt, b3.ack, b3.busy, b3.mem_en, b3.mem_we}); else n_pass++;
    n_total++; if ({b3.rdata, b3.mem_addr, b3.mem_wdata} !== 44'd0)
      $display("FAIL rst_mid_data: got %h want 0", {b3.rdata, b3.mem_addr, b3.mem_wdata}); else n_pass++;
    reset = 1'b0;
    b3.f_req = 1; b3.f_addr = 12'h123;
    tick();
    n_total++; if ({b3.gnt, b3.ack} !== {3'b001, 3'b000})
      $display("FAIL rst_mid_fresh: got %b/%b want 001/000", b3.gnt, b3.ack); else n_pass++;
    tick();
    tick();
    tick();
    n_total++; if ({b3.ack, b3.rdata} !== {3'b001, 16'hA5A5})
      $display("FAIL rst_mid_ack: got %b/%h want 001/a5a5", b3.ack, b3.rdata); else n_pass++;
    b3.f_req = 0; b3.d_req = 0;
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    bd_req  = 1'b0;
    bd_sel  = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    clear_inputs();
    test_reset();
    test_fetch_read();
    test_write_then_read();
    test_round_robin();
    test_isz();
    test_latency3();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
